pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage WISC-S15 core. It sits beside the IF/ID/EX stages and drives the IF_Unit/IFID_reg `hazard` (freeze) input, a bubble into IDEX_reg, and a flush of IFID_reg. Its inputs are ID-stage register usage, the EX-stage load destination and the EX-stage PC redirect. It sequences load-use stalls, ret resolution waits and redirect flushes through a small FSM.

Parameters:
LOAD_STALL_CYCLES, 1, total freeze cycles per load-use hazard; legal range 1..7.
REDIRECT_LAT, 1, extra flush cycles after the redirect cycle; legal range 0..7.
RET_TIMEOUT, 15, maximum cycles in RET_WAIT before abort; legal range 1..255.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-low (rst==0 resets)
id_valid  in  1  ID stage holds a real instruction
id_rs  in  4  ID source register rs
id_rt  in  4  ID source register rt
id_rs_used  in  1  instruction reads rs
id_rt_used  in  1  instruction reads rt
id_ret  in  1  ID instruction is ret
ex_mem_to_reg  in  1  EX instruction is a load
ex_reg_write  in  1  EX instruction writes regfile
ex_reg_rd  in  4  EX destination register
ex_pc_src  in  1  EX redirects PC this cycle (taken branch/call/ret)
ex_pc_update_done  in  1  EX finished branch/call/ret update
hazard  out  1  freeze PC and IFID_reg
idex_bubble  out  1  load NOP/zero controls into IDEX_reg
ifid_flush  out  1  load NOP into IFID_reg
ret_err  out  1  sticky: ret timed out
state_o  out  2  FSM state, for debug
stall_cnt_o  out  16  stall-cycle count (optional feature)
flush_cnt_o  out  16  flush-cycle count (optional feature)

Behaviour:
- Load-use term: lu = id_valid & ex_mem_to_reg & ex_reg_write & (ex_reg_rd!=0) & ((id_rs_used & id_rs==ex_reg_rd) | (id_rt_used & id_rt==ex_reg_rd)). R0 never hazards.
- States: RUN=0, LDSTALL=1, RET_WAIT=2, FLUSH=3. Outputs are combinational from state and inputs (Mealy). The state, the counters and ret_err are registered.
- While rst==0: state=RUN; counters=0; ret_err=0; hazard=0; idex_bubble=1; ifid_flush=1. A reset mid-stall or mid-wait aborts the sequence immediately.
- Priority in every state: ex_pc_src > lu > id_ret.
- Any state with ex_pc_src=1: hazard=0, idex_bubble=1, ifid_flush=1. If REDIRECT_LAT==0, next state is RUN. Otherwise next state is FLUSH with fl_cnt=REDIRECT_LAT.
- FLUSH: hazard=0, idex_bubble=1, ifid_flush=1. fl_cnt decrements each cycle. Go to RUN on the edge where fl_cnt==1.
- RUN, lu=1: hazard=1, idex_bubble=1, ifid_flush=0. If LOAD_STALL_CYCLES==1, stay in RUN. Otherwise go to LDSTALL with st_cnt=LOAD_STALL_CYCLES-1.
- LDSTALL: hazard=1, idex_bubble=1. st_cnt decrements. Go to RUN on the edge where st_cnt==1. lu is not re-evaluated here.
- RUN, id_valid & id_ret & !lu: hazard=0 (ret advances to EX), ifid_flush=1 (kill fall-through). Next state is RET_WAIT with to_cnt=0.
- RET_WAIT: hazard=1, ifid_flush=1, idex_bubble=1. to_cnt increments. Exit conditions:
  - ex_pc_src=1: redirect rule applies.
  - ex_pc_update_done=1 without ex_pc_src: go to RUN.
  - to_cnt==RET_TIMEOUT-1 at the edge: set ret_err=1 and go to RUN.
- ret_err clears only on reset.
- RUN with no event: all control outputs are 0.

Optional Feature:
HAZARD_STATS_EN.
- Defined: stall_cnt_o increments on every cycle with hazard=1 while rst==1. flush_cnt_o increments on every cycle with ifid_flush=1 while rst==1. Both are 16-bit, saturate at 0xFFFF, and reset to 0.
- Undefined: both ports are tied to 0 and no counter logic is built.

Test Plan:
- Load-use, defaults: ex_mem_to_reg=1, ex_reg_write=1, ex_reg_rd=3, id_rs=3, id_rs_used=1 -> hazard=1 and idex_bubble=1 for exactly 1 cycle; state stays RUN.
- Same with LOAD_STALL_CYCLES=3 -> hazard high 3 consecutive cycles; state_o goes 0,1,1,0.
- ex_reg_rd=0 with id_rs=0, and separately a match with id_rs_used=0 -> hazard stays 0.
- ex_pc_src=1 together with lu=1, REDIRECT_LAT=1 -> hazard=0; ifid_flush=1 and idex_bubble=1 for 2 cycles; then RUN.
- ret in ID, ex_pc_src pulses 2 cycles later -> ifid_flush high from the ret cycle through the redirect and FLUSH; no timeout. With no done/pc_src for 15 cycles -> ret_err=1, RUN. Assert rst=0 mid RET_WAIT -> RUN next cycle, ret_err=0.
- HAZARD_STATS_EN defined, 3 load-use stalls plus 1 redirect at defaults -> stall_cnt_o=3, flush_cnt_o=2. Undefined -> both read 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline hazard controller interface: ID/EX sideband in, freeze/bubble/flush out.
// Latency: none, plain wires between the pipeline and the controller.
// Backpressure: none; hazard is the freeze the pipeline must honour.
//
// Signals:
//   id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_ret : ID-stage usage
//   ex_mem_to_reg, ex_reg_write, ex_reg_rd                 : EX-stage load destination
//   ex_pc_src, ex_pc_update_done                           : EX-stage redirect status
//   hazard, idex_bubble, ifid_flush                        : pipeline controls
// Modports: master = pipeline side, slave = pipe_hazard_ctrl.
interface pipe_hazard_ctrl_if;
    logic       id_valid;
    logic [3:0] id_rs;
    logic [3:0] id_rt;
    logic       id_rs_used;
    logic       id_rt_used;
    logic       id_ret;
    logic       ex_mem_to_reg;
    logic       ex_reg_write;
    logic [3:0] ex_reg_rd;
    logic       ex_pc_src;
    logic       ex_pc_update_done;
    logic       hazard;
    logic       idex_bubble;
    logic       ifid_flush;

    modport master (
        output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_ret,
        output ex_mem_to_reg, ex_reg_write, ex_reg_rd, ex_pc_src, ex_pc_update_done,
        input  hazard, idex_bubble, ifid_flush
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_ret,
        input  ex_mem_to_reg, ex_reg_write, ex_reg_rd, ex_pc_src, ex_pc_update_done,
        output hazard, idex_bubble, ifid_flush
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, ret resolution waits, redirect flushes.
// Latency: controls are Mealy (same cycle as the inputs); state/counters update on clk.
// Backpressure: asserts hazard to freeze PC/IFID; never stalled itself.
//
// Ports:
//   clk, rst        : clock, synchronous active-low reset
//   pif (slave)     : ID/EX hazard inputs and hazard/idex_bubble/ifid_flush outputs
//   ret_err         : sticky, a ret waited RET_TIMEOUT cycles without resolving
//   state_o         : FSM state (RUN=0, LDSTALL=1, RET_WAIT=2, FLUSH=3)
//   stall_cnt_o     : saturating count of hazard cycles (HAZARD_STATS_EN), else 0
//   flush_cnt_o     : saturating count of ifid_flush cycles (HAZARD_STATS_EN), else 0
// Optional feature macro: HAZARD_STATS_EN.
module pipe_hazard_ctrl #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int REDIRECT_LAT      = 1,
    parameter int RET_TIMEOUT       = 15
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  pif,
    output logic               ret_err,
    output logic [1:0]         state_o,
    output logic [15:0]        stall_cnt_o,
    output logic [15:0]        flush_cnt_o
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LDSTALL  = 2'd1,
        RET_WAIT = 2'd2,
        FLUSH    = 2'd3
    } state_t;

    localparam logic [2:0] ST_INIT  = 3'(LOAD_STALL_CYCLES - 1);
    localparam logic [2:0] FL_INIT  = 3'(REDIRECT_LAT);
    localparam logic [7:0] TO_LAST  = 8'(RET_TIMEOUT - 1);
    localparam bit         LD_MULTI = (LOAD_STALL_CYCLES > 1);
    localparam bit         RL_ZERO  = (REDIRECT_LAT == 0);

    state_t     state, state_nxt;
    logic [2:0] st_cnt, st_nxt;
    logic [2:0] fl_cnt, fl_nxt;
    logic [7:0] to_cnt, to_nxt;
    logic       err_nxt;
    logic       lu;
    logic       hazard, idex_bubble, ifid_flush;

    // R0 is hardwired zero, so a load into it never creates a dependency.
    assign lu = pif.id_valid & pif.ex_mem_to_reg & pif.ex_reg_write &
                (pif.ex_reg_rd != 4'd0) &
                ((pif.id_rs_used & (pif.id_rs == pif.ex_reg_rd)) |
                 (pif.id_rt_used & (pif.id_rt == pif.ex_reg_rd)));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= RUN;
            st_cnt  <= 3'd0;
            fl_cnt  <= 3'd0;
            to_cnt  <= 8'd0;
            ret_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            st_cnt  <= st_nxt;
            fl_cnt  <= fl_nxt;
            to_cnt  <= to_nxt;
            ret_err <= err_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        st_nxt      = st_cnt;
        fl_nxt      = fl_cnt;
        to_nxt      = to_cnt;
        err_nxt     = ret_err;
        hazard      = 1'b0;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;

        if (!rst) begin
            // Keep the pipeline empty while held in reset.
            idex_bubble = 1'b1;
            ifid_flush  = 1'b1;
            state_nxt   = RUN;
        end else if (pif.ex_pc_src) begin
            // A redirect overrides whatever sequence was in progress.
            idex_bubble = 1'b1;
            ifid_flush  = 1'b1;
            if (RL_ZERO) begin
                state_nxt = RUN;
            end else begin
                state_nxt = FLUSH;
                fl_nxt    = FL_INIT;
            end
        end else begin
            unique case (state)
                FLUSH: begin
                    idex_bubble = 1'b1;
                    ifid_flush  = 1'b1;
                    fl_nxt      = fl_cnt - 3'd1;
                    if (fl_cnt == 3'd1) state_nxt = RUN;
                end
                LDSTALL: begin
                    // The dependent instruction is frozen in ID; lu is not rechecked.
                    hazard      = 1'b1;
                    idex_bubble = 1'b1;
                    st_nxt      = st_cnt - 3'd1;
                    if (st_cnt == 3'd1) state_nxt = RUN;
                end
                RET_WAIT: begin
                    hazard      = 1'b1;
                    idex_bubble = 1'b1;
                    ifid_flush  = 1'b1;
                    to_nxt      = to_cnt + 8'd1;
                    if (pif.ex_pc_update_done) begin
                        state_nxt = RUN;
                    end else if (to_cnt == TO_LAST) begin
                        err_nxt   = 1'b1;
                        state_nxt = RUN;
                    end
                end
                default: begin // RUN
                    if (lu) begin
                        hazard      = 1'b1;
                        idex_bubble = 1'b1;
                        if (LD_MULTI) begin
                            state_nxt = LDSTALL;
                            st_nxt    = ST_INIT;
                        end
                    end else if (pif.id_valid && pif.id_ret) begin
                        // Let the ret move to EX but kill the fall-through fetch.
                        ifid_flush = 1'b1;
                        state_nxt  = RET_WAIT;
                        to_nxt     = 8'd0;
                    end
                end
            endcase
        end
    end

    assign pif.hazard      = hazard;
    assign pif.idex_bubble = idex_bubble;
    assign pif.ifid_flush  = ifid_flush;
    assign state_o         = state;

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cnt, flush_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= 16'd0;
            flush_cnt <= 16'd0;
        end else begin
            if (hazard && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
            if (ifid_flush && (flush_cnt != 16'hFFFF)) flush_cnt <= flush_cnt + 16'd1;
        end
    end

    assign stall_cnt_o = stall_cnt;
    assign flush_cnt_o = flush_cnt;
`else
    assign stall_cnt_o = 16'd0;
    assign flush_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (default and non-default parameters) share stimulus.
// Latency: reference outputs compared each cycle 2ns after the falling edge.
// Backpressure: n/a.
module tb_pipe_hazard_ctrl;

    logic clk;
    logic rst;
    logic       id_valid, id_rs_used, id_rt_used, id_ret;
    logic [3:0] id_rs, id_rt, ex_reg_rd;
    logic       ex_mem_to_reg, ex_reg_write, ex_pc_src, ex_pc_update_done;

    int checks = 0;
    int errors = 0;

    // Per-instance parameters: index 0 = defaults, index 1 = stretched variant.
    int p_lsc[2] = '{1, 3};
    int p_rl[2]  = '{1, 2};
    int p_to[2]  = '{15, 5};

    pipe_hazard_ctrl_if if0 ();
    pipe_hazard_ctrl_if if1 ();

    logic        o_err[2];
    logic [1:0]  o_st[2];
    logic [15:0] o_sc[2];
    logic [15:0] o_fc[2];
    logic        o_hz[2], o_bb[2], o_fl[2];

    assign if0.id_valid = id_valid;            assign if1.id_valid = id_valid;
    assign if0.id_rs = id_rs;                  assign if1.id_rs = id_rs;
    assign if0.id_rt = id_rt;                  assign if1.id_rt = id_rt;
    assign if0.id_rs_used = id_rs_used;        assign if1.id_rs_used = id_rs_used;
    assign if0.id_rt_used = id_rt_used;        assign if1.id_rt_used = id_rt_used;
    assign if0.id_ret = id_ret;                assign if1.id_ret = id_ret;
    assign if0.ex_mem_to_reg = ex_mem_to_reg;  assign if1.ex_mem_to_reg = ex_mem_to_reg;
    assign if0.ex_reg_write = ex_reg_write;    assign if1.ex_reg_write = ex_reg_write;
    assign if0.ex_reg_rd = ex_reg_rd;          assign if1.ex_reg_rd = ex_reg_rd;
    assign if0.ex_pc_src = ex_pc_src;          assign if1.ex_pc_src = ex_pc_src;
    assign if0.ex_pc_update_done = ex_pc_update_done;
    assign if1.ex_pc_update_done = ex_pc_update_done;
    assign o_hz[0] = if0.hazard;      assign o_hz[1] = if1.hazard;
    assign o_bb[0] = if0.idex_bubble; assign o_bb[1] = if1.idex_bubble;
    assign o_fl[0] = if0.ifid_flush;  assign o_fl[1] = if1.ifid_flush;

    pipe_hazard_ctrl u_dut0 (
        .clk(clk), .rst(rst), .pif(if0.slave),
        .ret_err(o_err[0]), .state_o(o_st[0]),
        .stall_cnt_o(o_sc[0]), .flush_cnt_o(o_fc[0])
    );

    pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .REDIRECT_LAT(2), .RET_TIMEOUT(5)) u_dut1 (
        .clk(clk), .rst(rst), .pif(if1.slave),
        .ret_err(o_err[1]), .state_o(o_st[1]),
        .stall_cnt_o(o_sc[1]), .flush_cnt_o(o_fc[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: remaining freeze cycles, remaining flush cycles and age of the
    // outstanding ret (-1 when none) instead of an explicit state machine.
    int m_stall[2], m_flush[2], m_ret[2], m_err[2], m_sc[2], m_fc[2];

    task automatic model_reset_all();
        for (int i = 0; i < 2; i++) begin
            m_stall[i] = 0; m_flush[i] = 0; m_ret[i] = -1;
            m_err[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
        end
    endtask

    task automatic model_check();
        bit lu;
        int eh, eb, ef, es;
        lu = id_valid && ex_mem_to_reg && ex_reg_write && (ex_reg_rd != 0) &&
             ((id_rs_used && id_rs == ex_reg_rd) || (id_rt_used && id_rt == ex_reg_rd));
        for (int i = 0; i < 2; i++) begin
            es = (m_flush[i] > 0) ? 3 : (m_stall[i] > 0) ? 1 : (m_ret[i] >= 0) ? 2 : 0;
            eh = 0; eb = 0; ef = 0;
            if (!rst) begin
                eb = 1; ef = 1;
            end else if (ex_pc_src) begin
                eb = 1; ef = 1;
            end else if (m_flush[i] > 0) begin
                eb = 1; ef = 1;
            end else if (m_stall[i] > 0) begin
                eh = 1; eb = 1;
            end else if (m_ret[i] >= 0) begin
                eh = 1; eb = 1; ef = 1;
            end else if (lu) begin
                eh = 1; eb = 1;
            end else if (id_valid && id_ret) begin
                ef = 1;
            end
            chk($sformatf("hazard%0d", i), 32'(o_hz[i]), 32'(eh));
            chk($sformatf("bubble%0d", i), 32'(o_bb[i]), 32'(eb));
            chk($sformatf("flush%0d", i), 32'(o_fl[i]), 32'(ef));
            chk($sformatf("state%0d", i), 32'(o_st[i]), 32'(es));
            chk($sformatf("ret_err%0d", i), 32'(o_err[i]), 32'(m_err[i]));
`ifdef HAZARD_STATS_EN
            chk($sformatf("stall_cnt%0d", i), 32'(o_sc[i]), 32'(m_sc[i]));
            chk($sformatf("flush_cnt%0d", i), 32'(o_fc[i]), 32'(m_fc[i]));
`else
            chk($sformatf("stall_cnt%0d", i), 32'(o_sc[i]), 32'd0);
            chk($sformatf("flush_cnt%0d", i), 32'(o_fc[i]), 32'd0);
`endif
            // Advance to the state after the coming rising edge.
            if (!rst) begin
                m_stall[i] = 0; m_flush[i] = 0; m_ret[i] = -1;
                m_err[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
            end else begin
                if (eh == 1 && m_sc[i] < 65535) m_sc[i]++;
                if (ef == 1 && m_fc[i] < 65535) m_fc[i]++;
                if (ex_pc_src) begin
                    m_stall[i] = 0; m_ret[i] = -1; m_flush[i] = p_rl[i];
                end else if (m_flush[i] > 0) begin
                    m_flush[i]--;
                end else if (m_stall[i] > 0) begin
                    m_stall[i]--;
                end else if (m_ret[i] >= 0) begin
                    if (ex_pc_update_done) m_ret[i] = -1;
                    else if (m_ret[i] == p_to[i] - 1) begin
                        m_err[i] = 1; m_ret[i] = -1;
                    end else m_ret[i]++;
                end else if (lu) begin
                    m_stall[i] = p_lsc[i] - 1;
                end else if (id_valid && id_ret) begin
                    m_ret[i] = 0;
                end
            end
        end
    endtask

    task automatic tick();
        #2;
        model_check();
        @(negedge clk);
    endtask

    task automatic clear_in();
        rst = 1'b1; id_valid = 1'b0; id_rs = 4'd0; id_rt = 4'd0;
        id_rs_used = 1'b0; id_rt_used = 1'b0; id_ret = 1'b0;
        ex_mem_to_reg = 1'b0; ex_reg_write = 1'b0; ex_reg_rd = 4'd0;
        ex_pc_src = 1'b0; ex_pc_update_done = 1'b0;
    endtask

    task automatic set_lu(input logic [3:0] rd, input logic [3:0] rs, input logic used);
        id_valid = 1'b1; ex_mem_to_reg = 1'b1; ex_reg_write = 1'b1;
        ex_reg_rd = rd; id_rs = rs; id_rs_used = used;
    endtask

    task automatic idle(input int n);
        clear_in();
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic rand_in();
        rst               = ($urandom_range(0, 63) != 0);
        id_valid          = ($urandom_range(0, 9) != 0);
        id_rs             = 4'($urandom_range(0, 3));
        id_rt             = 4'($urandom_range(0, 3));
        id_rs_used        = 1'($urandom_range(0, 1));
        id_rt_used        = 1'($urandom_range(0, 1));
        id_ret            = ($urandom_range(0, 6) == 0);
        ex_mem_to_reg     = 1'($urandom_range(0, 1));
        ex_reg_write      = ($urandom_range(0, 3) != 0);
        ex_reg_rd         = 4'($urandom_range(0, 3));
        ex_pc_src         = ($urandom_range(0, 9) == 0);
        ex_pc_update_done = ($urandom_range(0, 9) == 0);
    endtask

    initial begin
        clear_in();
        rst = 1'b0;
        model_reset_all();
        @(negedge clk);
        tick();
        tick();

        // Load-use on r3 via rs.
        clear_in(); set_lu(4'd3, 4'd3, 1'b1); tick();
        idle(4);
        // R0 destination and unused source never stall.
        clear_in(); set_lu(4'd0, 4'd0, 1'b1); tick();
        clear_in(); set_lu(4'd5, 4'd5, 1'b0); tick();
        // Redirect wins over a simultaneous load-use.
        clear_in(); set_lu(4'd2, 4'd2, 1'b1); ex_pc_src = 1'b1; tick();
        idle(5);
        // ret resolved by a redirect two cycles later.
        clear_in(); id_valid = 1'b1; id_ret = 1'b1; tick();
        idle(1);
        ex_pc_src = 1'b1; tick();
        idle(4);
        // ret with no resolution times out.
        clear_in(); id_valid = 1'b1; id_ret = 1'b1; tick();
        idle(20);
        chk("timeout_err0", 32'(o_err[0]), 32'd1);
        chk("timeout_err1", 32'(o_err[1]), 32'd1);
        // Reset in the middle of a ret wait.
        clear_in(); id_valid = 1'b1; id_ret = 1'b1; tick();
        idle(2);
        rst = 1'b0; tick();
        clear_in();
        chk("rst_mid_state0", 32'(o_st[0]), 32'd0);
        chk("rst_mid_err0", 32'(o_err[0]), 32'd0);
        tick();

        // Three load-use stalls plus one redirect from a clean reset.
        rst = 1'b0; tick();
        for (int k = 0; k < 3; k++) begin
            clear_in(); set_lu(4'd3, 4'd3, 1'b1); tick();
            idle(3);
        end
        clear_in(); ex_pc_src = 1'b1; tick();
        idle(3);
`ifdef HAZARD_STATS_EN
        chk("stats_stall0", 32'(o_sc[0]), 32'd3);
        chk("stats_flush0", 32'(o_fc[0]), 32'd2);
`else
        chk("stats_stall0", 32'(o_sc[0]), 32'd0);
        chk("stats_flush0", 32'(o_fc[0]), 32'd0);
`endif

        for (int k = 0; k < 800; k++) begin
            rand_in();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
